// File: rtl/i2c_target_fsm_if.sv
// Bus and register-side signal bundle for the single-address I2C target.
// rx_valid and tx_req are one-clk pulses with no backpressure: rx_data is valid in the rx_valid cycle, tx_data must be held from tx_req until the next SCL fall.
interface i2c_target_fsm_if #(
    parameter int DATA_LEN = 8
) ();

    logic                scl_in;
    logic                sda_in;
    logic                sda_oe;
    logic                ack_en;
    logic [DATA_LEN-1:0] rx_data;
    logic                rx_valid;
    logic                tx_req;
    logic [DATA_LEN-1:0] tx_data;
    logic                busy;

    modport slave (
        input  scl_in,
        input  sda_in,
        input  ack_en,
        input  tx_data,
        output sda_oe,
        output rx_data,
        output rx_valid,
        output tx_req,
        output busy
    );

    modport master (
        output scl_in,
        output sda_in,
        output ack_en,
        output tx_data,
        input  sda_oe,
        input  rx_data,
        input  rx_valid,
        input  tx_req,
        input  busy
    );

endinterface

// File: rtl/i2c_target_fsm.sv
// Single-address I2C target: oversampled SCL/SDA, START/STOP detection, address match,
// write-byte reception and read-byte service. SDA is open-drain (low request only), SCL is never driven.
module i2c_target_fsm #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         DATA_LEN    = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    i2c_target_fsm_if.slave      bus,
    output logic [2:0]           state_o
);

    localparam int SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CNT_MAX = (DATA_LEN > 8) ? DATA_LEN : 8;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_ADDR_DONE = CNT_W'(8);
    localparam logic [CNT_W-1:0] CNT_BYTE_LAST = CNT_W'(DATA_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_BYTE_DONE = CNT_W'(DATA_LEN);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WRITE     = 3'd3,
        WR_ACK    = 3'd4,
        READ      = 3'd5,
        RD_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    // Synchronizers reset to the idle-bus level so reset release never fakes a START.
    logic [SYNC_N-1:0] scl_sync_q;
    logic [SYNC_N-1:0] sda_sync_q;
    logic              scl_prev_q;
    logic              sda_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_N-2:0], bus.scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_N-2:0], bus.sda_in};
            scl_prev_q <= scl_sync_q[SYNC_N-1];
            sda_prev_q <= sda_sync_q[SYNC_N-1];
        end
    end

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_evt;
    logic stop_evt;

    assign scl_s     = scl_sync_q[SYNC_N-1];
    assign sda_s     = sda_sync_q[SYNC_N-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_evt = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_evt  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    state_t              state_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [7:0]          addr_sr_q;
    logic [DATA_LEN-2:0] shift_q;
    logic                rw_q;
    logic                sda_oe_q;
    logic [DATA_LEN-1:0] rx_data_q;
    logic                rx_valid_q;
    logic                tx_req_q;
    logic                busy_q;

    logic [7:0]          addr_in_d;
    logic [DATA_LEN-1:0] shift_in_d;
    logic                addr_hit_d;

    assign addr_in_d  = {addr_sr_q[6:0], sda_s};
    assign shift_in_d = {shift_q, sda_s};
    // At the rise of the R/W bit the seven address bits sit in the low end of the shifter.
    assign addr_hit_d = (addr_sr_q[6:0] == TARGET_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            addr_sr_q  <= '0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            if (stop_evt) begin
                state_q   <= IDLE;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
                bit_cnt_q <= '0;
            end else if (start_evt) begin
                state_q   <= ADDR;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b1;
                bit_cnt_q <= '0;
            end else begin
                case (state_q)
                    ADDR: begin
                        if (scl_rise && (bit_cnt_q < CNT_ADDR_DONE)) begin
                            addr_sr_q <= addr_in_d;
                            bit_cnt_q <= bit_cnt_q + CNT_ONE;
                            // Only a matching read asks the register side for data.
                            if ((bit_cnt_q == CNT_ADDR_LAST) && sda_s && addr_hit_d) begin
                                tx_req_q <= 1'b1;
                            end
                        end else if (scl_fall && (bit_cnt_q == CNT_ADDR_DONE)) begin
                            bit_cnt_q <= '0;
                            if (addr_sr_q[7:1] == TARGET_ADDR) begin
                                state_q  <= ADDR_ACK;
                                sda_oe_q <= 1'b1;
                                rw_q     <= addr_sr_q[0];
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt_q <= '0;
                            if (rw_q) begin
                                state_q  <= READ;
                                shift_q  <= bus.tx_data[DATA_LEN-2:0];
                                sda_oe_q <= ~bus.tx_data[DATA_LEN-1];
                            end else begin
                                state_q  <= WRITE;
                                sda_oe_q <= 1'b0;
                            end
                        end
                    end

                    WRITE: begin
                        if (scl_rise && (bit_cnt_q < CNT_BYTE_DONE)) begin
                            shift_q   <= shift_in_d[DATA_LEN-2:0];
                            bit_cnt_q <= bit_cnt_q + CNT_ONE;
                            if (bit_cnt_q == CNT_BYTE_LAST) begin
                                rx_data_q  <= shift_in_d;
                                rx_valid_q <= 1'b1;
                            end
                        end else if (scl_fall && (bit_cnt_q == CNT_BYTE_DONE)) begin
                            state_q   <= WR_ACK;
                            sda_oe_q  <= bus.ack_en;
                            bit_cnt_q <= '0;
                        end
                    end

                    WR_ACK: begin
                        if (scl_fall) begin
                            state_q   <= WRITE;
                            sda_oe_q  <= 1'b0;
                            bit_cnt_q <= '0;
                        end
                    end

                    READ: begin
                        if (scl_rise && (bit_cnt_q < CNT_BYTE_DONE)) begin
                            bit_cnt_q <= bit_cnt_q + CNT_ONE;
                        end else if (scl_fall && (bit_cnt_q != '0)) begin
                            if (bit_cnt_q == CNT_BYTE_DONE) begin
                                state_q   <= RD_ACK;
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= '0;
                            end else begin
                                shift_q  <= shift_q << 1;
                                sda_oe_q <= ~shift_q[DATA_LEN-2];
                            end
                        end
                    end

                    RD_ACK: begin
                        // bit_cnt_q == 1 records that the master ACKed and a new byte is due.
                        if (scl_rise && (bit_cnt_q == '0)) begin
                            if (sda_s) begin
                                state_q <= WAIT_STOP;
                            end else begin
                                bit_cnt_q <= CNT_ONE;
                                tx_req_q  <= 1'b1;
                            end
                        end else if (scl_fall && (bit_cnt_q == CNT_ONE)) begin
                            state_q   <= READ;
                            bit_cnt_q <= '0;
                            shift_q   <= bus.tx_data[DATA_LEN-2:0];
                            sda_oe_q  <= ~bus.tx_data[DATA_LEN-1];
                        end
                    end

                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_req   = tx_req_q;
    assign bus.busy     = busy_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_i2c_target_fsm.sv
// Directed bench for i2c_target_fsm: a bit-banged bus master plus a scoreboard
// that matches rx_valid/tx_req pulses against queued expectations.
module tb_i2c_target_fsm;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_WAIT_STOP = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       ack_en_m = 1'b1;
    logic [2:0] state_dbg;

    int total = 0;
    int bad = 0;

    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] mon_e;
    logic       watch_oe = 1'b0;
    logic       oe_seen = 1'b0;

    always #5 clk = ~clk;

    i2c_target_fsm_if #(.DATA_LEN(8)) bus ();

    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;
    assign bus.ack_en = ack_en_m;

    i2c_target_fsm #(
        .TARGET_ADDR (7'h50),
        .DATA_LEN    (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT pulses an output.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.tx_data = '0;
        end else begin
            if (bus.rx_valid) begin
                check("rx_valid_expected", 32'(exp_rx_q.size() != 0), 32'd1);
                if (exp_rx_q.size() != 0) begin
                    mon_e = exp_rx_q.pop_front();
                    check("rx_data", 32'(bus.rx_data), 32'(mon_e));
                end
            end
            if (bus.tx_req) begin
                check("tx_req_expected", 32'(exp_tx_q.size() != 0), 32'd1);
                if (exp_tx_q.size() != 0) begin
                    bus.tx_data = exp_tx_q.pop_front();
                end
            end
            if (watch_oe && bus.sda_oe) oe_seen = 1'b1;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCL period; SDA changes only while SCL is low, line sampled mid-high.
    task automatic scl_bit(input logic b, output logic r);
        wait_clk(4);
        sda_m = b;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(4);
        r = bus.sda_in;
        wait_clk(4);
        scl_m = 1'b0;
    endtask

    task automatic send_start();
        wait_clk(4);
        sda_m = 1'b1;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(4);
        sda_m = 1'b0;
        wait_clk(4);
        scl_m = 1'b0;
    endtask

    task automatic send_stop();
        wait_clk(4);
        sda_m = 1'b0;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(4);
        sda_m = 1'b1;
        wait_clk(8);
    endtask

    task automatic send8(input logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) scl_bit(b[i], r);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic r;
        send8(b);
        scl_bit(1'b1, r);
        acked = ~r;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic m_ack);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            scl_bit(1'b1, r);
            b[i] = r;
        end
        scl_bit(~m_ack, r);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       acked;
        logic       r;
        logic [7:0] rd;

        wait_clk(3);
        check("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_tx_req", 32'(bus.tx_req), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst_n = 1'b1;
        wait_clk(10);

        // Write 0xA5 to 0x50 with ACK.
        send_start();
        check("wr_busy_start", 32'(bus.busy), 32'd1);
        check("wr_state_start", 32'(state_dbg), 32'(ST_ADDR));
        write_byte(8'hA0, acked);
        check("wr_addr_ack", 32'(acked), 32'd1);
        exp_rx_q.push_back(8'hA5);
        write_byte(8'hA5, acked);
        check("wr_data_ack", 32'(acked), 32'd1);
        send_stop();
        check("wr_state_stop", 32'(state_dbg), 32'(ST_IDLE));
        check("wr_busy_stop", 32'(bus.busy), 32'd0);
        check("wr_rx_data_hold", 32'(bus.rx_data), 32'hA5);

        // Address mismatch: 0x51 write, then 0xFF.
        send_start();
        check("mm_busy_start", 32'(bus.busy), 32'd1);
        oe_seen = 1'b0;
        watch_oe = 1'b1;
        send8(8'hA2);
        wait_clk(5);
        check("mm_busy_9th_fall", 32'(bus.busy), 32'd0);
        check("mm_state_9th_fall", 32'(state_dbg), 32'(ST_IDLE));
        scl_bit(1'b1, r);
        check("mm_addr_nack", 32'(r), 32'd1);
        write_byte(8'hFF, acked);
        check("mm_data_nack", 32'(acked), 32'd0);
        send_stop();
        watch_oe = 1'b0;
        check("mm_sda_oe_never", 32'(oe_seen), 32'd0);

        // Read 0x3C (master ACK) then 0xC3 (master NACK).
        exp_tx_q.push_back(8'h3C);
        exp_tx_q.push_back(8'hC3);
        send_start();
        write_byte(8'hA1, acked);
        check("rd_addr_ack", 32'(acked), 32'd1);
        read_byte(rd, 1'b1);
        check("rd_byte0", 32'(rd), 32'h3C);
        read_byte(rd, 1'b0);
        check("rd_byte1", 32'(rd), 32'hC3);
        wait_clk(5);
        check("rd_sda_oe_after_nack", 32'(bus.sda_oe), 32'd0);
        check("rd_state_wait_stop", 32'(state_dbg), 32'(ST_WAIT_STOP));
        check("rd_busy_wait_stop", 32'(bus.busy), 32'd1);
        send_stop();
        check("rd_state_stop", 32'(state_dbg), 32'(ST_IDLE));

        // NACKed write of 0x12.
        ack_en_m = 1'b0;
        send_start();
        write_byte(8'hA0, acked);
        check("nk_addr_ack", 32'(acked), 32'd1);
        exp_rx_q.push_back(8'h12);
        write_byte(8'h12, acked);
        check("nk_data_nack", 32'(acked), 32'd0);
        send_stop();
        ack_en_m = 1'b1;

        // Repeated START after three data bits, then a read of 0x5A.
        send_start();
        write_byte(8'hA0, acked);
        check("rs_addr_w_ack", 32'(acked), 32'd1);
        scl_bit(1'b1, r);
        scl_bit(1'b0, r);
        scl_bit(1'b1, r);
        send_start();
        check("rs_state_addr", 32'(state_dbg), 32'(ST_ADDR));
        exp_tx_q.push_back(8'h5A);
        write_byte(8'hA1, acked);
        check("rs_addr_r_ack", 32'(acked), 32'd1);
        read_byte(rd, 1'b0);
        check("rs_read_byte", 32'(rd), 32'h5A);
        wait_clk(5);
        check("rs_state_wait_stop", 32'(state_dbg), 32'(ST_WAIT_STOP));
        send_stop();

        // Reset while the target pulls SDA low in a read.
        exp_tx_q.push_back(8'h00);
        send_start();
        write_byte(8'hA1, acked);
        check("rr_addr_ack", 32'(acked), 32'd1);
        wait_clk(5);
        check("rr_sda_oe_before", 32'(bus.sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rr_sda_oe_in_reset", 32'(bus.sda_oe), 32'd0);
        check("rr_busy_in_reset", 32'(bus.busy), 32'd0);
        check("rr_state_in_reset", 32'(state_dbg), 32'(ST_IDLE));
        wait_clk(3);
        rst_n = 1'b1;
        oe_seen = 1'b0;
        watch_oe = 1'b1;
        send8(8'h00);
        scl_bit(1'b1, r);
        check("rr_ignored_no_ack", 32'(r), 32'd1);
        check("rr_ignored_busy", 32'(bus.busy), 32'd0);
        send_stop();
        watch_oe = 1'b0;
        check("rr_sda_oe_never", 32'(oe_seen), 32'd0);
        send_start();
        write_byte(8'hA0, acked);
        check("rr_new_addr_ack", 32'(acked), 32'd1);
        exp_rx_q.push_back(8'h3F);
        write_byte(8'h3F, acked);
        check("rr_new_data_ack", 32'(acked), 32'd1);
        send_stop();

        wait_clk(10);
        check("rx_q_drained", 32'(exp_rx_q.size()), 32'd0);
        check("tx_q_drained", 32'(exp_tx_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
